// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, feature-map geometry and ping-pong FSM encoding
package cnn_pkg;
  localparam int DATA_W = 8;
  localparam int FMAP_H = 28;
  localparam int FMAP_W = 28;
  localparam int DEPTH = FMAP_H * FMAP_W;
  localparam int ADDR_LEN = 9;
  localparam int AW = ADDR_LEN + 1;
  localparam int FILL_COUNT = 676;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A = AW'(FILL_COUNT - 1);
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_READ  = 2'd1,
    FULL_READ  = 2'd2
  } state_t;
endpackage

// File: rtl/fmap_bank.sv
// fmap_bank: DEPTH x DATA_W store, one write port, two synchronous read ports
module fmap_bank
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr1,
  input  logic [AW-1:0]            i_raddr2,
  output logic signed [DATA_W-1:0] o_rdata1,
  output logic signed [DATA_W-1:0] o_rdata2
);
  logic signed [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata1 <= r_mem[i_raddr1];
    o_rdata2 <= r_mem[i_raddr2];
  end
endmodule

// File: rtl/fmap_pingpong_buf.sv
// fmap_pingpong_buf: two-bank feature-map store, one bank fills while the other is read
module fmap_pingpong_buf
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_store,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_done,
  output logic                     wr_ready,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic signed [DATA_W-1:0] rd_data1,
  output logic signed [DATA_W-1:0] rd_data2,
  output logic                     rd_valid,
  input  logic                     rd_release,
  output logic                     swap,
  output logic [AW-1:0]            wr_count,
  output logic                     overflow
);
  state_t r_state, w_next;
  logic r_wr_sel, r_rsel, r_z1, r_z2;
  logic w_acc, w_complete, w_do_swap;
  logic signed [DATA_W-1:0] w_b0_d1, w_b0_d2, w_b1_d1, w_b1_d2;
  assign wr_ready = r_state != FULL_READ;
  assign rd_valid = r_state != FILL_EMPTY;
  assign w_acc = wr_store & wr_ready & (wr_addr < DEPTH_A);
  // completion cannot happen while the write side is blocked
  assign w_complete = wr_ready & (wr_done | (w_acc & wr_count == LAST_A));
  always_comb begin
    w_do_swap = (r_state == FILL_EMPTY & w_complete) |
                (r_state == FILL_READ & w_complete & rd_release) |
                (r_state == FULL_READ & rd_release);
    w_next = w_do_swap ? FILL_READ :
             (r_state == FILL_READ & w_complete) ? FULL_READ :
             (r_state == FILL_READ & rd_release) ? FILL_EMPTY : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL_EMPTY;
      r_wr_sel <= 1'b0;
      wr_count <= '0;
      overflow <= 1'b0;
      swap <= 1'b0;
      r_rsel <= 1'b1;
      r_z1 <= 1'b1;
      r_z2 <= 1'b1;
    end else begin
      r_state <= w_next;
      r_wr_sel <= r_wr_sel ^ w_do_swap;
      wr_count <= w_do_swap ? '0 : w_acc ? wr_count + 1'b1 : wr_count;
      overflow <= overflow | (wr_store & ~w_acc);
      swap <= w_do_swap;
      r_rsel <= ~r_wr_sel;
      r_z1 <= rd_addr1 >= DEPTH_A;
      r_z2 <= rd_addr2 >= DEPTH_A;
    end
  end
  fmap_bank u_bank0 (
    .clk(clk), .i_we(w_acc & ~r_wr_sel), .i_waddr(wr_addr), .i_wdata(wr_data),
    .i_raddr1(rd_addr1), .i_raddr2(rd_addr2), .o_rdata1(w_b0_d1), .o_rdata2(w_b0_d2)
  );
  fmap_bank u_bank1 (
    .clk(clk), .i_we(w_acc & r_wr_sel), .i_waddr(wr_addr), .i_wdata(wr_data),
    .i_raddr1(rd_addr1), .i_raddr2(rd_addr2), .o_rdata1(w_b1_d1), .o_rdata2(w_b1_d2)
  );
  assign rd_data1 = r_z1 ? '0 : r_rsel ? w_b1_d1 : w_b0_d1;
  assign rd_data2 = r_z2 ? '0 : r_rsel ? w_b1_d2 : w_b0_d2;
endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// tb_fmap_pingpong_buf: directed scenarios for the ping-pong feature-map buffer
module tb_fmap_pingpong_buf;
  logic clk = 0, rst = 0, wr_store = 0, wr_done = 0, rd_release = 0;
  logic [9:0] wr_addr = 0, rd_addr1 = 0, rd_addr2 = 0, wr_count;
  logic signed [7:0] wr_data = 0, rd_data1, rd_data2;
  logic wr_ready, rd_valid, swap, overflow;
  int n_cmp = 0, n_err = 0;

  fmap_pingpong_buf dut (
    .clk(clk), .rst(rst), .wr_store(wr_store), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid(rd_valid), .rd_release(rd_release),
    .swap(swap), .wr_count(wr_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; tick(); rst = 0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    n_cmp++; if (swap !== 1'b0) begin n_err++; $display("FAIL reset_swap got %0b want 0", swap); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_cmp++; if (wr_count !== 10'd0) begin n_err++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
    n_cmp++; if (rd_data1 !== 8'sd0) begin n_err++; $display("FAIL reset_rd_data1 got %0d want 0", rd_data1); end
  endtask

  task automatic test_fill_first;
    for (int k = 0; k < 676; k++) begin
      wr_store = 1; wr_addr = 10'(k); wr_data = 8'(k - 128);
      tick();
      if (k == 674) begin
        n_cmp++; if (wr_count !== 10'd675 || swap !== 1'b0) begin n_err++; $display("FAIL fill1_pre got count=%0d swap=%0b want 675/0", wr_count, swap); end
      end
    end
    wr_store = 0;
    n_cmp++; if (swap !== 1'b1) begin n_err++; $display("FAIL fill1_swap got %0b want 1", swap); end
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL fill1_rd_valid got %0b want 1", rd_valid); end
    n_cmp++; if (wr_count !== 10'd0) begin n_err++; $display("FAIL fill1_wr_count got %0d want 0", wr_count); end
  endtask

  task automatic test_read_first;
    rd_addr1 = 0; rd_addr2 = 675; tick();
    n_cmp++; if (swap !== 1'b0) begin n_err++; $display("FAIL read1_swap_pulse got %0b want 0", swap); end
    n_cmp++; if (rd_data1 !== -8'sd128) begin n_err++; $display("FAIL read1_d1 got %0d want -128", rd_data1); end
    n_cmp++; if (rd_data2 !== 8'sd35) begin n_err++; $display("FAIL read1_d2 got %0d want 35", rd_data2); end
  endtask

  task automatic test_full_read;
    for (int k = 0; k < 676; k++) begin
      wr_store = 1; wr_addr = 10'(k); wr_data = 8'(k + 5);
      tick();
    end
    wr_store = 0;
    n_cmp++; if (wr_ready !== 1'b0 || rd_valid !== 1'b1 || swap !== 1'b0) begin n_err++; $display("FAIL full_state got ready=%0b valid=%0b swap=%0b want 0/1/0", wr_ready, rd_valid, swap); end
    n_cmp++; if (rd_data2 !== 8'sd35) begin n_err++; $display("FAIL full_old_bank got %0d want 35", rd_data2); end
    wr_store = 1; wr_addr = 3; wr_data = 99; tick(); wr_store = 0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_overflow got %0b want 1", overflow); end
    n_cmp++; if (wr_count !== 10'd676) begin n_err++; $display("FAIL full_count_hold got %0d want 676", wr_count); end
    rd_release = 1; tick(); rd_release = 0;
    n_cmp++; if (swap !== 1'b1 || wr_ready !== 1'b1 || wr_count !== 10'd0) begin n_err++; $display("FAIL full_release got swap=%0b ready=%0b count=%0d want 1/1/0", swap, wr_ready, wr_count); end
    rd_addr1 = 3; rd_addr2 = 675; tick();
    n_cmp++; if (rd_data1 !== 8'sd8) begin n_err++; $display("FAIL full_read_d1 got %0d want 8", rd_data1); end
    n_cmp++; if (rd_data2 !== -8'sd88) begin n_err++; $display("FAIL full_read_d2 got %0d want -88", rd_data2); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) begin
      wr_store = 1; wr_addr = 10'(k); wr_data = 8'(k + 50);
      wr_done = (k == 4); rd_release = (k == 4);
      tick();
    end
    wr_store = 0; wr_done = 0; rd_release = 0;
    n_cmp++; if (swap !== 1'b1 || rd_valid !== 1'b1 || wr_ready !== 1'b1 || wr_count !== 10'd0) begin n_err++; $display("FAIL b2b_swap got swap=%0b valid=%0b ready=%0b count=%0d want 1/1/1/0", swap, rd_valid, wr_ready, wr_count); end
    rd_addr1 = 2; tick();
    n_cmp++; if (swap !== 1'b0 || rd_valid !== 1'b1 || wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_single got swap=%0b valid=%0b ready=%0b want 0/1/1", swap, rd_valid, wr_ready); end
    n_cmp++; if (rd_data1 !== 8'sd52) begin n_err++; $display("FAIL b2b_read got %0d want 52", rd_data1); end
  endtask

  task automatic test_early_done;
    rst = 1; tick(); rst = 0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL early_overflow_clear got %0b want 0", overflow); end
    for (int k = 0; k < 10; k++) begin
      wr_store = 1; wr_addr = 10'(k); wr_data = 8'(k * 7);
      tick();
    end
    wr_addr = 800; wr_data = 1; tick(); wr_store = 0;
    n_cmp++; if (overflow !== 1'b1 || wr_count !== 10'd10) begin n_err++; $display("FAIL early_oob_write got ovf=%0b count=%0d want 1/10", overflow, wr_count); end
    wr_done = 1; tick(); wr_done = 0;
    n_cmp++; if (swap !== 1'b1 || rd_valid !== 1'b1 || wr_count !== 10'd0) begin n_err++; $display("FAIL early_swap got swap=%0b valid=%0b count=%0d want 1/1/0", swap, rd_valid, wr_count); end
    rd_addr1 = 790; rd_addr2 = 9; tick();
    n_cmp++; if (rd_data1 !== 8'sd0) begin n_err++; $display("FAIL early_oob_read got %0d want 0", rd_data1); end
    n_cmp++; if (rd_data2 !== 8'sd63) begin n_err++; $display("FAIL early_read got %0d want 63", rd_data2); end
  endtask

  task automatic test_mid_reset;
    for (int k = 0; k < 300; k++) begin
      wr_store = 1; wr_addr = 10'(k); wr_data = 8'(k);
      tick();
    end
    wr_store = 0; wr_done = 1; tick(); wr_done = 0;
    n_cmp++; if (wr_ready !== 1'b0 || wr_count !== 10'd300 || overflow !== 1'b1) begin n_err++; $display("FAIL mid_pre got ready=%0b count=%0d ovf=%0b want 0/300/1", wr_ready, wr_count, overflow); end
    n_cmp++; if (rd_data2 !== 8'sd63) begin n_err++; $display("FAIL mid_pre_read got %0d want 63", rd_data2); end
    rst = 1; tick(); rst = 0;
    n_cmp++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || swap !== 1'b0 || overflow !== 1'b0 || wr_count !== 10'd0) begin n_err++; $display("FAIL mid_reset got ready=%0b valid=%0b swap=%0b ovf=%0b count=%0d want 1/0/0/0/0", wr_ready, rd_valid, swap, overflow, wr_count); end
    n_cmp++; if (rd_data1 !== 8'sd0 || rd_data2 !== 8'sd0) begin n_err++; $display("FAIL mid_reset_data got %0d/%0d want 0/0", rd_data1, rd_data2); end
  endtask

  initial begin
    test_reset();
    test_fill_first();
    test_read_first();
    test_full_read();
    test_back_to_back();
    test_early_done();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
